// File: rtl/rr_hold_arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Optional assertions in the top are enabled by RR_HOLD_ARB_SVA_EN.
package rr_hold_arb_pkg;

    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    function automatic int unsigned wrap_inc(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// Rotating priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [IDW:0]   j;
    logic [IDW-1:0] jj;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        jj    = '0;
        for (int i = 0; i < N; i++) begin
            j = {1'b0, ptr} + (IDW+1)'(i);
            if (j >= (IDW+1)'(N)) begin
                j = j - (IDW+1)'(N);
            end
            jj = j[IDW-1:0];
            if (!valid && req[jj]) begin
                valid = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with hold-until-done grants and bounded hold time.
// Define RR_HOLD_ARB_SVA_EN to enable embedded protocol assertions.
module rr_hold_arbiter
    import rr_hold_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout,
    output logic           req_drop
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic           to_q, to_d;
    logic           rd_q, rd_d;
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic           hold_max;
    logic           owner_req;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign hold_max  = (hold_q == HW'(MAX_HOLD));
    assign owner_req = req[id_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        to_d    = 1'b0;
        rd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << pick_idx;
                    id_d    = pick_idx;
                    hold_d  = HW'(1);
                end
            end
            GRANT: begin
                if (done || !owner_req || hold_max) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    id_d    = '0;
                    hold_d  = '0;
                    ptr_d   = IDW'(wrap_inc(32'(id_q), N));
                    // done wins; otherwise a dropped req outranks timeout
                    if (!done) begin
                        rd_d = !owner_req;
                        to_d = owner_req;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            to_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            to_q    <= to_d;
            rd_q    <= rd_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = id_q;
    assign busy     = (state_q == GRANT);
    assign timeout  = to_q;
    assign req_drop = rd_q;

`ifdef RR_HOLD_ARB_SVA_EN
    a_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(gnt)
    ) else $error("%0t: gnt not onehot0", $time);

    a_done_rel: assert property (
        @(posedge clk) disable iff (rst) busy && done |=> !busy
    ) else $error("%0t: busy after done", $time);

    a_hold_max: assert property (
        @(posedge clk) disable iff (rst) not (busy [* MAX_HOLD+1])
    ) else $error("%0t: hold exceeded", $time);

    for (genvar i = 0; i < N; i++) begin : g_sva
        a_rose: assert property (
            @(posedge clk) disable iff (rst) $rose(gnt[i]) |-> req[i]
        ) else $error("%0t: grant %0d without req", $time, i);

        a_live: assert property (
            @(posedge clk) disable iff (rst)
            req[i] && !gnt[i] |-> req[i] [* 1:$] ##1 gnt[i]
        ) else $error("%0t: req %0d starved", $time, i);
    end

    c_wrap: cover property (
        @(posedge clk) disable iff (rst)
        $fell(gnt[N-1]) ##[1:3] $rose(gnt[0])
    );
`endif

endmodule
